dma_word_ctrl: RTL
==================

// Module: dma_word_ctrl
// PURPOSE
//  Word-count / transfer-termination side of the Am2940 DMA address generator.
//  The address counter steps the bus address. This block counts the words moved and terminates the transfer.
//  It latches a word count, counts each transfer strobe in one of four Am2940 modes, and raises DONE.
//  It sits beside the address counter and takes that counter's current address and carry as compare inputs.
// PARAMETERS
//  W      8   width of word count register, word counter, and address compare
// PORTS
//  clk      in   1  system clock; all state changes on rising edge
//  res      in   1  synchronous active-high reset
//  di       in   W  data in for word count register (WCR)
//  ld_wcr   in   1  load WCR from di
//  mode     in   2  transfer mode, sampled on start (00 dec-to-0, 01 cnt-compare, 10 addr-compare, 11 carry)
//  start    in   1  begin transfer: init word counter (WC) per mode, enter RUN
//  xfer     in   1  one word transferred this cycle (count strobe)
//  addr     in   W  current address from address counter (mode 10 compare)
//  wc_o     out  W  word counter value
//  wcr_o    out  W  word count register value
//  busy     out  1  high in RUN
//  done     out  1  high in DONE, held until start or res
//  tc       out  1  one-cycle pulse on the cycle DONE is entered
// BEHAVIOUR
//  Reset: res=1 at an edge -> WCR=0, WC=0, mode_q=00, state=IDLE, busy=0, done=0, tc=0.
//   Reset overrides every other input and aborts RUN immediately.
//  FSM states: IDLE, RUN, DONE. All outputs registered; no comb paths input->output.
//   IDLE --start--> RUN
//   RUN --terminal--> DONE (tc=1 that cycle)
//   DONE --start--> RUN
//   start in RUN restarts: WC re-initialised, stays RUN
//  start: mode_q<=mode.
//   WC init: mode 00 and 11 -> WC<=WCR; mode 01 and 10 -> WC<=0.
//  Zero length: start with WCR==0 in mode 00 or 01 -> next state DONE, not RUN.
//   In that case tc pulses one cycle later and no xfer is counted.
//  xfer in RUN, by mode:
//   00 WC<=WC-1; terminal when new WC==0
//   01 WC<=WC+1; terminal when new WC==WCR
//   10 WC<=WC+1; terminal when addr==WCR, sampled in the xfer cycle
//   11 WC<=WC+1 mod 2^W; terminal on wrap FF->00 (WCR=0 => 256 words)
//  xfer in IDLE or DONE: ignored; WC unchanged.
//  start and xfer in the same cycle: start wins, xfer dropped.
//  ld_wcr: WCR<=di in any state.
//   If ld_wcr coincides with start, WC init and zero check use the OLD WCR.
//   In RUN, compare modes use the new WCR from the next cycle.
//  Arithmetic: modulo 2^W, no saturation. Mode 00 never underflows, because it terminates at 0.
//  WC and WCR hold their values in DONE, so the count is readable after the transfer.
// TESTING
//  1 res=1 one cycle, then idle -> wc_o=0, wcr_o=0, busy=0, done=0, tc=0
//  2 ld_wcr di=8'h03; start mode=00; 3 xfer -> wc_o 3,2,1,0; done=1 after 3rd; tc one pulse
//  3 WCR=8'h02, mode=01, start, xfer x2 -> wc_o 0,1,2, done; extra xfer in DONE -> wc_o stays 2
//  4 WCR=8'h40, mode=10; xfer with addr=8'h3f -> busy; xfer with addr=8'h40 -> done
//  5 WCR=8'hfe, mode=11, start; xfer x2 -> wc_o ff then 00, done=1 on the wrap
//  6 WCR=0, mode=00, start -> DONE next cycle, tc=1; res mid-RUN -> IDLE, all outputs 0

Source files
------------

// File: rtl/dma_word_ctrl.sv
// Word-count / termination side of an Am2940-style DMA generator: latches a
// word count, counts transfer strobes in one of four modes and flags DONE.
module dma_word_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         res,
  input  logic [W-1:0] di,
  input  logic         ld_wcr,
  input  logic [1:0]   mode,
  input  logic         start,
  input  logic         xfer,
  input  logic [W-1:0] addr,
  output logic [W-1:0] wc_o,
  output logic [W-1:0] wcr_o,
  output logic         busy,
  output logic         done,
  output logic         tc
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] wc_q, wc_d;
  logic [W-1:0] wcr_q, wcr_d;
  logic [1:0]   mode_q, mode_d;
  logic         tc_q, tc_d;
  logic [W-1:0] wc_inc, wc_dec;
  logic         term;

  assign wc_inc = wc_q + 1'b1;
  assign wc_dec = wc_q - 1'b1;

  // Terminal condition for an xfer seen in RUN, evaluated against the current WCR.
  always_comb begin
    term = 1'b0;
    case (mode_q)
      2'b00:   term = (wc_dec == '0);
      2'b01:   term = (wc_inc == wcr_q);
      2'b10:   term = (addr == wcr_q);
      default: term = (wc_q == {W{1'b1}});
    endcase
  end

  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    wcr_d   = ld_wcr ? di : wcr_q;
    mode_d  = mode_q;
    tc_d    = 1'b0;
    if (start) begin
      // Init and zero-length check use the pre-load WCR.
      mode_d = mode;
      wc_d   = (mode == 2'b00 || mode == 2'b11) ? wcr_q : '0;
      if (wcr_q == '0 && !mode[1]) begin
        state_d = S_DONE;
        tc_d    = 1'b1;
      end else begin
        state_d = S_RUN;
      end
    end else if (state_q == S_RUN && xfer) begin
      wc_d = (mode_q == 2'b00) ? wc_dec : wc_inc;
      if (term) begin
        state_d = S_DONE;
        tc_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= S_IDLE;
      wc_q    <= '0;
      wcr_q   <= '0;
      mode_q  <= 2'b00;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      wcr_q   <= wcr_d;
      mode_q  <= mode_d;
      tc_q    <= tc_d;
    end
  end

  assign wc_o  = wc_q;
  assign wcr_o = wcr_q;
  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);
  assign tc    = tc_q;

endmodule
